// File: rtl/ring_rotator_pkg.sv
// ring_rotator shared definitions: FSM state encoding, rotation direction
// constants and default geometry. Imported by the interface, ring_ctrl and
// ring_rotator.
package ring_pkg;

   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ROTATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   // Direction of a single step: DOWN moves data toward index 0,
   // UP moves data toward index DEPTH-1.
   localparam logic DIR_DOWN = 1'b0;
   localparam logic DIR_UP   = 1'b1;

endpackage : ring_pkg

// File: rtl/ring_rotator_if.sv
// ring_rotator bus: parallel load, start/amount/dir request and the
// busy/done/ring contents returned by the rotator.
interface ring_rotator_if
   import ring_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AMT_W = $clog2(DEPTH) + 1
) ();

   logic                   load;
   logic [WIDTH*DEPTH-1:0] load_data;
   logic                   start;
   logic [AMT_W-1:0]       amount;
   logic                   dir;
   logic                   busy;
   logic                   done;
   logic [WIDTH*DEPTH-1:0] ring_data;
   logic [WIDTH-1:0]       head;

   // Control path side: issues requests, observes status and contents.
   modport master (
      output load, load_data, start, amount, dir,
      input  busy, done, ring_data, head
   );

   // Rotator side.
   modport slave (
      input  load, load_data, start, amount, dir,
      output busy, done, ring_data, head
   );

endinterface : ring_rotator_if

// File: rtl/ring_rotator_ctrl.sv
// ring_ctrl: IDLE/ROTATE/DONE sequencer for ring_rotator. Holds the step
// counter and latched direction, and tells the datapath when to load and
// when to take one rotation step.
// Build option RING_DIR_EN: when defined the dir request is latched;
// otherwise every rotation is toward index 0.
module ring_ctrl
   import ring_pkg::*;
#(
   parameter int AMT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             start,
   input  logic [AMT_W-1:0] amount,
   input  logic             dir,
   output logic             load_en,
   output logic             step,
   output logic             step_dir,
   output logic             busy,
   output logic             done
);

   state_t           state_r;
   logic [AMT_W-1:0] cnt_r;
   logic             dir_q_r;
   logic             busy_r;
   logic             done_r;

`ifndef RING_DIR_EN
   // dir is accepted on the port but has no effect in this build.
   logic unused_dir_s;
   assign unused_dir_s = dir;
`endif

   // Sequencer: state, step count, direction and registered status flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         dir_q_r <= DIR_DOWN;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (load) begin
                  // Load takes priority; a simultaneous start is dropped.
                  busy_r <= 1'b0;
                  done_r <= 1'b0;
               end else if (start) begin
                  cnt_r  <= amount;
`ifdef RING_DIR_EN
                  dir_q_r <= dir;
`else
                  dir_q_r <= DIR_DOWN;
`endif
                  busy_r <= 1'b1;
                  if (amount != '0) begin
                     state_r <= ROTATE;
                     done_r  <= 1'b0;
                  end else begin
                     state_r <= DONE;
                     done_r  <= 1'b1;
                  end
               end else begin
                  busy_r <= 1'b0;
                  done_r <= 1'b0;
               end
            end
            ROTATE: begin
               cnt_r  <= cnt_r - AMT_W'(1);
               busy_r <= 1'b1;
               if (cnt_r == AMT_W'(1)) begin
                  state_r <= DONE;
                  done_r  <= 1'b1;
               end else begin
                  done_r  <= 1'b0;
               end
            end
            DONE: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= '0;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign load_en  = (state_r == IDLE) && load;
   assign step     = (state_r == ROTATE);
   assign step_dir = dir_q_r;
   assign busy     = busy_r;
   assign done     = done_r;

endmodule : ring_ctrl

// File: rtl/ring_rotator.sv
// ring_rotator: DEPTH registered stages of WIDTH bits that rotate one stage
// per clock under a start/busy/done handshake, with parallel load.
// Build option RING_DIR_EN: when defined, dir selects rotation toward
// index 0 or toward index DEPTH-1; otherwise only toward index 0 is built.
module ring_rotator
   import ring_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int AMT_W = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   ring_rotator_if.slave bus
);

   logic [DEPTH-1:0][WIDTH-1:0] stage_r;
   logic [DEPTH-1:0][WIDTH-1:0] stage_next_s;
   logic [DEPTH-1:0][WIDTH-1:0] rot_down_s;
   logic                        load_en_s;
   logic                        step_s;
   logic                        step_dir_s;

   ring_ctrl #(
      .AMT_W (AMT_W)
   ) u_ctrl (
      .clk      (clk),
      .rst      (rst),
      .load     (bus.load),
      .start    (bus.start),
      .amount   (bus.amount),
      .dir      (bus.dir),
      .load_en  (load_en_s),
      .step     (step_s),
      .step_dir (step_dir_s),
      .busy     (bus.busy),
      .done     (bus.done)
   );

   // Down step: stage[i] takes stage[i+1], the top stage wraps from stage 0.
   assign rot_down_s = {stage_r[0], stage_r[DEPTH-1:1]};

`ifdef RING_DIR_EN
   logic [DEPTH-1:0][WIDTH-1:0] rot_up_s;
   // Up step: stage[i] takes stage[i-1], stage 0 wraps from the top stage.
   assign rot_up_s = {stage_r[DEPTH-2:0], stage_r[DEPTH-1]};

   // Next ring contents: load, one step in the latched direction, or hold.
   always_comb begin
      stage_next_s = stage_r;
      if (load_en_s) begin
         stage_next_s = bus.load_data;
      end else if (step_s) begin
         if (step_dir_s == DIR_UP) begin
            stage_next_s = rot_up_s;
         end else begin
            stage_next_s = rot_down_s;
         end
      end else begin
         stage_next_s = stage_r;
      end
   end
`else
   logic unused_step_dir_s;
   assign unused_step_dir_s = step_dir_s;

   // Next ring contents: load, one step toward index 0, or hold.
   always_comb begin
      stage_next_s = stage_r;
      if (load_en_s) begin
         stage_next_s = bus.load_data;
      end else if (step_s) begin
         stage_next_s = rot_down_s;
      end else begin
         stage_next_s = stage_r;
      end
   end
`endif

   // Stage registers, cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         stage_r <= '0;
      end else begin
         stage_r <= stage_next_s;
      end
   end

   assign bus.ring_data = stage_r;
   assign bus.head      = stage_r[0];

endmodule : ring_rotator

// File: tb/tb_ring_rotator.sv
// Directed bench for ring_rotator (WIDTH=8, DEPTH=4) with hand-computed
// expected ring contents and handshake timing.
module tb_ring_rotator;

   logic clk;
   logic rst;
   int   checks_n;
   int   errors_n;

   ring_rotator_if #(.WIDTH(8), .DEPTH(4), .AMT_W(3)) bus ();

   ring_rotator #(.WIDTH(8), .DEPTH(4), .AMT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_n++;
      if (got !== exp) begin
         errors_n++;
         $display("FAIL %s got=0x%08h exp=0x%08h @%0t", tag, got, exp, $time);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] data);
      bus.load      = 1'b1;
      bus.load_data = data;
      tick();
      bus.load      = 1'b0;
      chk("load_ring", bus.ring_data, data);
   endtask

   // Issue a start and check busy/done on every cycle through DONE and the
   // IDLE cycle that follows.
   task automatic run(input string tag, input logic [2:0] amt, input logic d,
                      input logic [31:0] exp_ring);
      int n;
      n = int'(amt);
      bus.start  = 1'b1;
      bus.amount = amt;
      bus.dir    = d;
      tick();
      bus.start  = 1'b0;
      for (int k = 1; k <= n + 1; k++) begin
         chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
         chk({tag, "_done"}, 32'(bus.done), (k == n + 1) ? 32'd1 : 32'd0);
         if (k < n + 1) tick();
      end
      chk({tag, "_ring"}, bus.ring_data, exp_ring);
      chk({tag, "_head"}, 32'(bus.head), 32'(exp_ring[7:0]));
      tick();
      chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_idle_done"}, 32'(bus.done), 32'd0);
      chk({tag, "_idle_ring"}, bus.ring_data, exp_ring);
   endtask

   initial begin
      logic [31:0] exp_up;
      checks_n      = 0;
      errors_n      = 0;
      rst           = 1'b1;
      bus.load      = 1'b0;
      bus.load_data = 32'h0;
      bus.start     = 1'b0;
      bus.amount    = 3'd0;
      bus.dir       = 1'b0;
      tick();
      tick();
      chk("rst_ring", bus.ring_data, 32'h0);
      chk("rst_head", 32'(bus.head), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      rst = 1'b0;

      do_load(32'h44332211);
      chk("load_head", 32'(bus.head), 32'h11);
      chk("load_busy", 32'(bus.busy), 32'd0);

      // Reset wins over a load in the same cycle.
      bus.load      = 1'b1;
      bus.load_data = 32'hAABBCCDD;
      rst           = 1'b1;
      tick();
      rst      = 1'b0;
      bus.load = 1'b0;
      chk("rst_load_ring", bus.ring_data, 32'h0);

      // Single step down, then a back-to-back second step.
      do_load(32'h44332211);
      run("a1", 3'd1, 1'b0, 32'h11443322);
      run("a1_b2b", 3'd1, 1'b0, 32'h22114433);

      // amount larger than DEPTH performs every step.
      do_load(32'h44332211);
      run("a5", 3'd5, 1'b0, 32'h11443322);

      // Direction request.
`ifdef RING_DIR_EN
      exp_up = 32'h33221144;
`else
      exp_up = 32'h11443322;
`endif
      do_load(32'h44332211);
      run("up1", 3'd1, 1'b1, exp_up);

      // Zero amount: one busy/done cycle, ring unchanged.
      do_load(32'h44332211);
      run("a0", 3'd0, 1'b0, 32'h44332211);

      // Load and start together: load wins, no operation.
      bus.load      = 1'b1;
      bus.load_data = 32'h55667788;
      bus.start     = 1'b1;
      bus.amount    = 3'd2;
      tick();
      bus.load  = 1'b0;
      bus.start = 1'b0;
      chk("ls_ring", bus.ring_data, 32'h55667788);
      chk("ls_busy", 32'(bus.busy), 32'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("ls_nodone", 32'(bus.done), 32'd0);
         chk("ls_nobusy", 32'(bus.busy), 32'd0);
      end
      chk("ls_hold", bus.ring_data, 32'h55667788);

      // Load during ROTATE is ignored.
      do_load(32'h44332211);
      bus.start  = 1'b1;
      bus.amount = 3'd3;
      bus.dir    = 1'b0;
      tick();
      bus.start     = 1'b0;
      bus.load      = 1'b1;
      bus.load_data = 32'hFFFFFFFF;
      chk("rl_busy1", 32'(bus.busy), 32'd1);
      tick();
      tick();
      tick();
      bus.load = 1'b0;
      chk("rl_done", 32'(bus.done), 32'd1);
      chk("rl_ring", bus.ring_data, 32'h33221144);
      tick();
      chk("rl_idle_ring", bus.ring_data, 32'h33221144);

      // Reset mid-rotation aborts with no done pulse.
      do_load(32'h44332211);
      bus.start  = 1'b1;
      bus.amount = 3'd3;
      tick();
      bus.start = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("ab_busy", 32'(bus.busy), 32'd0);
      chk("ab_done", 32'(bus.done), 32'd0);
      chk("ab_ring", bus.ring_data, 32'h0);
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("ab_nodone", 32'(bus.done), 32'd0);
         chk("ab_nobusy", 32'(bus.busy), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
      $finish;
   end

endmodule : tb_ring_rotator

// File: doc/ring_rotator.md
# ring_rotator

Parametrised circular register ring: DEPTH stages of WIDTH bits that rotate one stage per clock under a start/busy/done handshake. Supersedes the fixed four-signal combinational ring with registered stages, parallel load, programmable rotate amount and optional bidirectional rotation. Sits in the SCCPU datapath as a general rotate/queue-circulate unit driven by the control path.

## Interface
- WIDTH, 8, bits per stage (>=1)
- DEPTH, 4, number of stages (>=2)
- AMT_W, $clog2(DEPTH)+1, width of rotate amount
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- load  in  1  parallel-load request
- load_data  in  WIDTH*DEPTH  stage i = bits [i*WIDTH +: WIDTH]
- start  in  1  rotate request
- amount  in  AMT_W  number of single-stage steps
- dir  in  1  0 = toward index 0, 1 = toward index DEPTH-1
- busy  out  1  operation in progress, inputs ignored
- done  out  1  one-cycle completion pulse
- ring_data  out  WIDTH*DEPTH  current ring contents
- head  out  WIDTH  stage 0

## Operation
- FSM states: IDLE, ROTATE, DONE.
- IDLE: load=1 -> all stages <= load_data, stay IDLE. Else start=1 -> latch amount into cnt and dir into dir_q; go to ROTATE if amount!=0, otherwise DONE.
- load and start in the same IDLE cycle: load wins; start is dropped and no done is produced.
- ROTATE: each edge performs one step and decrements cnt. At cnt==1 -> DONE.
- Step, dir_q=0: stage[i] <= stage[(i+1) mod DEPTH]. Stage 0 takes stage 1 and stage DEPTH-1 takes stage 0.
- Step, dir_q=1: stage[i] <= stage[(i-1) mod DEPTH].
- DONE: done=1 for one cycle, ring holds its value, then IDLE.
- load, start, amount and dir are ignored in ROTATE and DONE.
- There is no modulo reduction of amount. amount >= DEPTH performs all steps, which gives the same result as amount mod DEPTH.
- head and ring_data are continuous views of the stage registers.

## Timing
- Reset values: all stages 0, state IDLE, cnt 0, busy 0, done 0, ring_data 0, head 0.
- Reset in the middle of an operation aborts it: next cycle IDLE, ring cleared, no done pulse.
- A start sampled at edge of cycle T (amount=N>0) gives:
  - busy high from T+1 through T+N+1.
  - done high in cycle T+N+1.
  - ring_data final, and stable in that cycle.
- amount=0: busy and done high in T+1 only; ring unchanged.
- A load sampled at edge T is visible on ring_data in cycle T+1.
- Back-to-back operation: a new start is accepted in the first IDLE cycle after DONE. The minimum issue interval is N+2 cycles.
- busy is a registered function of state (ROTATE or DONE). done is a registered function of state (DONE). No combinational input-to-output paths.

## Configuration
- RING_DIR_EN defined:
  - dir is honoured as above.
- RING_DIR_EN undefined:
  - dir port remains but is ignored.
  - dir_q is tied to 0.
  - Only rotation toward index 0 is built, with no up-direction mux.
  - All other behaviour is identical.

## Structure
- Shared package ring_pkg holds:
  - state enum (IDLE, ROTATE, DONE).
  - DIR_DOWN=1'b0 and DIR_UP=1'b1 constants.
- One sub-module, ring_ctrl, is natural. It holds the FSM, cnt and dir_q, and outputs step, step_dir, busy and done.
- The stage array and rotate muxing live in ring_rotator.

## Test plan
- Reset, then load 0x44332211 (WIDTH=8, DEPTH=4) -> ring_data=0x44332211 and head=0x11 the next cycle. Assert rst mid-load -> all 0.
- start, amount=1, dir=0 -> done at T+2, ring_data=0x11443322, head=0x22. Repeat with amount=5 -> same result, done at T+6.
- With RING_DIR_EN: amount=1, dir=1 on 0x44332211 -> 0x33221144, head=0x44. Without the macro, the same stimulus -> 0x11443322.
- amount=0 -> busy and done high in T+1 only, ring_data unchanged. load and start in the same cycle -> ring loaded, busy stays 0, no done.
- Start amount=3. During ROTATE assert load=1 with 0xFFFFFFFF -> load ignored; result 0x33221144 from 0x44332211.
- Start amount=3, assert rst in cycle T+2 -> next cycle busy=0, done=0, ring_data=0. No done pulse afterwards.
